// File: rtl/gcd_sched_if.sv
// Bundle between gcd_sched, its requesters and the shared subtractive GCD core.
// slave is the scheduler's view; master is the view of the surrounding logic.
interface gcd_sched_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] x_req;
  logic [N*W-1:0] y_req;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           err;
  logic           busy;
  logic [IDW-1:0] cur_id;
  logic           dp_go;
  logic [W-1:0]   dp_xin;
  logic [W-1:0]   dp_yin;
  logic           dp_done;
  logic [W-1:0]   dp_gcd;

  modport slave (
    input  req, x_req, y_req, dp_done, dp_gcd,
    output ack, result, err, busy, cur_id, dp_go, dp_xin, dp_yin
  );

  modport master (
    output req, x_req, y_req, dp_done, dp_gcd,
    input  ack, result, err, busy, cur_id, dp_go, dp_xin, dp_yin
  );
endinterface

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one subtractive GCD core between N requesters.
// Zero operands are answered locally; a watchdog aborts core runs that never finish.
module gcd_sched #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned TMO = 2048
) (
  input  logic        clk,
  input  logic        clr,
  gcd_sched_if.slave  bus
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW  = $clog2(TMO);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TMO - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state_q, state_n;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [W-1:0]   xl_q, xl_d, yl_q, yl_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           go_q, go_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [W-1:0]   win_x, win_y;
  logic           win_zero;
  logic           timeout;

  // First pending request at or above ptr, wrapping modulo N.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_any && bus.req[IDW'((32'(ptr_q) + k) % N)]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((32'(ptr_q) + k) % N);
      end
    end
  end

  // Winner's operands.
  always_comb begin
    win_x = '0;
    win_y = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_id == IDW'(i)) begin
        win_x = bus.x_req[i*W +: W];
        win_y = bus.y_req[i*W +: W];
      end
    end
  end

  assign win_zero = (win_x == '0) || (win_y == '0);
  assign timeout  = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_n = win_zero ? RESP : LAUNCH;
      LAUNCH:  state_n = WAIT;
      WAIT:    if (bus.dp_done || timeout) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs.
  always_comb begin
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    xl_d     = xl_q;
    yl_d     = yl_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cur_id_d = gnt_id;
          xl_d     = win_x;
          yl_d     = win_y;
          if (win_zero) begin
            result_d = win_x | win_y;
            err_d    = 1'b0;
          end
        end
      end
      LAUNCH: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.dp_done) begin
          result_d = bus.dp_gcd;
          err_d    = 1'b0;
        end else if (timeout) begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      RESP: ptr_d = (cur_id_q == ID_LAST) ? '0 : cur_id_q + IDW'(1);
      default: ;
    endcase
    ack_d  = (state_n == RESP) ? (N'(1) << cur_id_d) : '0;
    busy_d = (state_n != IDLE);
    go_d   = (state_n == LAUNCH);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q    <= '0;
      cur_id_q <= '0;
      xl_q     <= '0;
      yl_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      xl_q     <= xl_d;
      yl_q     <= yl_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      go_q     <= go_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.cur_id = cur_id_q;
  assign bus.dp_go  = go_q;
  assign bus.dp_xin = xl_q;
  assign bus.dp_yin = yl_q;
endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: N=4, W=8, TMO=16, with an inline core model.
module tb_gcd_sched;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gcd_sched_if #(.N(4), .W(8)) bus ();
  gcd_sched #(.N(4), .W(8), .TMO(16)) dut (.clk(clk), .clr(clr), .bus(bus));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [7:0] x, input logic [7:0] y);
    bus.x_req[i*8 +: 8] = x;
    bus.y_req[i*8 +: 8] = y;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.x_req = '0; bus.y_req = '0; bus.dp_done = 1'b0; bus.dp_gcd = '0;
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    tick();
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.result !== 8'd0 || bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_result: got %0d/%b expected 0/0", bus.result, bus.err); end
    vectors++; if (bus.cur_id !== 2'd0 || bus.dp_go !== 1'b0) begin miscompares++; $display("FAIL reset_id_go: got %0d/%b expected 0/0", bus.cur_id, bus.dp_go); end
    vectors++; if (bus.dp_xin !== 8'd0 || bus.dp_yin !== 8'd0) begin miscompares++; $display("FAIL reset_xy: got %0d/%0d expected 0/0", bus.dp_xin, bus.dp_yin); end
  endtask

  task automatic test_single_job();
    set_ops(0, 8'd48, 8'd18);
    bus.req = 4'b0001;
    tick();
    vectors++; if (bus.dp_go !== 1'b1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_go: got go=%b busy=%b expected 1/1", bus.dp_go, bus.busy); end
    vectors++; if (bus.dp_xin !== 8'd48 || bus.dp_yin !== 8'd18) begin miscompares++; $display("FAIL single_ops: got %0d/%0d expected 48/18", bus.dp_xin, bus.dp_yin); end
    bus.req = 4'b0000;
    tick();
    vectors++; if (bus.dp_go !== 1'b0) begin miscompares++; $display("FAIL single_go_width: got %b expected 0", bus.dp_go); end
    repeat (9) tick();
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL single_early_ack: got %b expected 0000", bus.ack); end
    bus.dp_done = 1'b1; bus.dp_gcd = 8'd6;
    tick();
    bus.dp_done = 1'b0; bus.dp_gcd = 8'd0;
    vectors++; if (bus.ack !== 4'b0001) begin miscompares++; $display("FAIL single_ack: got %b expected 0001", bus.ack); end
    vectors++; if (bus.result !== 8'd6 || bus.err !== 1'b0) begin miscompares++; $display("FAIL single_result: got %0d/%b expected 6/0", bus.result, bus.err); end
    tick();
    vectors++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got ack=%b busy=%b expected 0000/0", bus.ack, bus.busy); end
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 2, 3, 0, 2};
    logic [3:0] exp_ack;
    bit found;
    pulse_clr();
    for (int i = 0; i < 4; i++) set_ops(i, 8'd0, 8'(i + 1));
    bus.req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        tick();
        if (bus.ack !== 4'b0000) found = 1'b1;
      end
      exp_ack = 4'b0001 << order[n];
      vectors++;
      if (!found || bus.ack !== exp_ack || bus.result !== 8'(order[n] + 1)) begin
        miscompares++;
        $display("FAIL fair_order_%0d: got ack=%b result=%0d expected ack=%b result=%0d", n, bus.ack, bus.result, exp_ack, order[n] + 1);
      end
      bus.req[order[n]] = 1'b0;
      if (n == 3) bus.req = 4'b0101;
    end
    tick();
  endtask

  task automatic test_zero_operands();
    logic [7:0] xs [3] = '{8'd0, 8'd12, 8'd0};
    logic [7:0] ys [3] = '{8'd35, 8'd0, 8'd0};
    logic [7:0] rs [3] = '{8'd35, 8'd12, 8'd0};
    for (int n = 0; n < 3; n++) begin
      set_ops(1, xs[n], ys[n]);
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0000;
      vectors++;
      if (bus.ack !== 4'b0010 || bus.result !== rs[n] || bus.err !== 1'b0 || bus.dp_go !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_%0d: got ack=%b result=%0d err=%b go=%b expected 0010/%0d/0/0", n, bus.ack, bus.result, bus.err, bus.dp_go, rs[n]);
      end
      tick();
      vectors++; if (bus.dp_go !== 1'b0 || bus.ack !== 4'b0000) begin miscompares++; $display("FAIL zero_idle_%0d: got go=%b ack=%b expected 0/0000", n, bus.dp_go, bus.ack); end
    end
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    set_ops(0, 8'd0, 8'd4);
    set_ops(1, 8'd7, 8'd0);
    bus.req = 4'b0011;
    tick();
    vectors++; if (bus.ack !== 4'b0001 || bus.result !== 8'd4) begin miscompares++; $display("FAIL b2b_first: got %b/%0d expected 0001/4", bus.ack, bus.result); end
    bus.req = 4'b0010;
    tick();
    vectors++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got ack=%b busy=%b expected 0000/0", bus.ack, bus.busy); end
    tick();
    vectors++; if (bus.ack !== 4'b0010 || bus.result !== 8'd7) begin miscompares++; $display("FAIL b2b_second: got %b/%0d expected 0010/7", bus.ack, bus.result); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    set_ops(2, 8'd5, 8'd3);
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    vectors++; if (bus.dp_go !== 1'b1) begin miscompares++; $display("FAIL tmo_go: got %b expected 1", bus.dp_go); end
    early = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.ack !== 4'b0000) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL tmo_early_ack: got %0d ack cycles expected 0", early); end
    tick();
    vectors++; if (bus.ack !== 4'b0100 || bus.err !== 1'b1 || bus.result !== 8'd0) begin miscompares++; $display("FAIL tmo_ack: got ack=%b err=%b result=%0d expected 0100/1/0", bus.ack, bus.err, bus.result); end
    tick();
    set_ops(2, 8'd21, 8'd14);
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    vectors++; if (bus.dp_go !== 1'b1 || bus.dp_xin !== 8'd21 || bus.dp_yin !== 8'd14) begin miscompares++; $display("FAIL tmo_next_go: got go=%b %0d/%0d expected 1 21/14", bus.dp_go, bus.dp_xin, bus.dp_yin); end
    repeat (7) tick();
    bus.dp_done = 1'b1; bus.dp_gcd = 8'd7;
    tick();
    bus.dp_done = 1'b0;
    vectors++; if (bus.ack !== 4'b0100 || bus.err !== 1'b0 || bus.result !== 8'd7) begin miscompares++; $display("FAIL tmo_next_ack: got ack=%b err=%b result=%0d expected 0100/0/7", bus.ack, bus.err, bus.result); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_ops(0, 8'd9, 8'd6);
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick(); tick();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rst_wait_busy: got %b expected 1", bus.busy); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin miscompares++; $display("FAIL rst_wait_clear: got busy=%b ack=%b expected 0/0000", bus.busy, bus.ack); end
    bus.dp_done = 1'b1; bus.dp_gcd = 8'd3;
    tick();
    bus.dp_done = 1'b0;
    tick();
    vectors++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.result !== 8'd0) begin miscompares++; $display("FAIL rst_late_done: got ack=%b busy=%b result=%0d expected 0000/0/0", bus.ack, bus.busy, bus.result); end
  endtask

  task automatic test_operand_stability();
    int moved;
    set_ops(3, 8'd48, 8'd18);
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b0000;
    set_ops(3, 8'd99, 8'd18);
    moved = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.dp_xin !== 8'd48) moved++;
    end
    vectors++; if (moved != 0) begin miscompares++; $display("FAIL stab_wait: got %0d cycles with dp_xin!=48 expected 0", moved); end
    bus.dp_done = 1'b1; bus.dp_gcd = 8'd6;
    tick();
    bus.dp_done = 1'b0;
    vectors++; if (bus.ack !== 4'b1000 || bus.result !== 8'd6 || bus.dp_xin !== 8'd48) begin miscompares++; $display("FAIL stab_resp: got ack=%b result=%0d xin=%0d expected 1000/6/48", bus.ack, bus.result, bus.dp_xin); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fairness();
    test_zero_operands();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_operand_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule

// File: doc/gcd_sched.md
# gcd_sched

Round-robin scheduler that shares one subtractive GCD datapath (mux/register/subtractor/compare core driven by its control unit) between N independent requesters. It arbitrates among pending requests, latches the winner's operands, launches the core with a one-cycle go, waits for its done strobe, and returns the result with a one-cycle acknowledge. Zero operands are resolved locally, because the subtractive core never terminates on them. A watchdog also aborts runs that never finish. It sits between the requesting logic and the GCD core, replacing direct drive of the core's go/xin/yin inputs.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, operand/result width
- TMO, 2048, max cycles in WAIT before abort (≥2)

- clk  in  1  rising-edge clock
- clr  in  1  reset, synchronous, active-high
- req  in  N  request per requester, level
- x_req  in  N*W  operand x, requester i at bits [i*W +: W]
- y_req  in  N*W  operand y, same packing
- ack  out  N  one-hot, one-cycle completion pulse to the serviced requester
- result  out  W  GCD, valid only while ack ≠ 0
- err  out  1  timeout flag, valid only while ack ≠ 0
- busy  out  1  high whenever state ≠ IDLE
- cur_id  out  clog2(N)  index of the requester being serviced
- dp_go  out  1  start pulse to the GCD core
- dp_xin, dp_yin  out  W each  operands to the core
- dp_done  in  1  one-cycle pulse from the core when its result register loads
- dp_gcd  in  W  core result, valid with dp_done

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req ≠ 0, grant the first set bit searching upward from ptr, wrapping modulo N.
  - Latch the winner's index into cur_id and its operands into xl/yl.
  - If xl==0 or yl==0, load result = xl|yl (gcd(0,0)=0), set err=0 and go to RESP.
  - Otherwise go to LAUNCH.
- LAUNCH: dp_go=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Count cycles.
  - On dp_done=1, capture result=dp_gcd, set err=0 and go to RESP.
  - If the count reaches TMO-1 with no done, set result=0, err=1 and go to RESP.
  - When done and timeout coincide, done wins.
- RESP:
  - ack[cur_id]=1, with result and err driven.
  - Set ptr = (cur_id+1) mod N.
  - Go to IDLE.
- dp_xin/dp_yin equal xl/yl at all times, stable from LAUNCH through WAIT. Requester operand changes after grant have no effect.
- dp_done outside WAIT is ignored.
- Requesters hold req and operands until grant. A req still high in the cycle after ack is treated as a new request.
- Arithmetic: no width growth. result is W bits, and the counter is clog2(TMO) bits.

## Timing
- Reset (clr=1 at an edge):
  - state=IDLE, ptr=0, ack=0, result=0, err=0, busy=0, cur_id=0, dp_go=0, xl=yl=0.
  - clr mid-operation abandons the job with no ack. A later dp_done is ignored.
- Non-zero path:
  - req sampled in IDLE at edge t.
  - LAUNCH (dp_go high) in cycle t+1.
  - WAIT from t+2.
  - dp_done in cycle d gives ack in cycle d+1.
- Zero path: req sampled at t gives ack in cycle t+1. dp_go never asserts.
- Timeout: ack with err=1 in the cycle after the TMO-th WAIT cycle.
- Back-to-back: after RESP, IDLE takes one cycle. The minimum spacing between grants is 2 cycles on the zero path and 4 on the core path (done in first WAIT cycle).
- ack, result, err, busy and dp_go are registered.

## Test plan
- Single job:
  - Stimulus: req=0001, x=48, y=18; core model pulses dp_done with 6 ten cycles after dp_go.
  - Response: dp_go one cycle after grant with dp_xin=48, dp_yin=18. ack=0001 one cycle after done, result=6, err=0.
- Fairness:
  - Stimulus: req=1111 held after reset, each requester drops req after its ack; then req=0101.
  - Response: ack order 0,1,2,3, then 0,2.
- Zero operands:
  - Stimulus: x=0, y=35, then x=0, y=0.
  - Response: ack the cycle after grant with result=35, then result=0; dp_go stays 0 throughout.
- Timeout:
  - Stimulus: TMO=16, core never signals done.
  - Response: ack with err=1, result=0, in the cycle after the 16th WAIT cycle. The next request (x=21, y=14, done 7) completes normally.
- Reset mid-WAIT:
  - Stimulus: clr pulsed during WAIT, then dp_done arrives.
  - Response: busy=0 and ack=0 the next cycle; the late dp_done causes no ack.
- Operand stability:
  - Stimulus: x_req changes from 48 to 99 during WAIT.
  - Response: dp_xin stays 48 until RESP.
